// File: rtl/trace_drain_arbiter.sv
// Round-robin drain of NUM_SOURCES trace buffers into one valid/ready consumer.
// One request outstanding at a time; the record is captured REQ_LATENCY cycles after the request.
package trace_pkg;
  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
    logic [15:0] event_id;
  } trace_data_t;

  typedef struct packed {
    logic [3:0]  core_id;
    logic [3:0]  flags;
    trace_data_t if_data;
  } trace_output;
endpackage

module trace_drain_arbiter #(
  parameter  int NUM_SOURCES = 4,
  parameter  int REQ_LATENCY = 1,
  parameter  int COUNT_WIDTH = 16,
  localparam int SRC_W       = $clog2(NUM_SOURCES)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_SOURCES-1:0]                    src_data_present,
  output logic [NUM_SOURCES-1:0]                    src_data_request,
  input  trace_pkg::trace_output [NUM_SOURCES-1:0]  src_trace_element,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output trace_pkg::trace_output                    out_trace,
  output logic [SRC_W-1:0]                          out_source,
  output logic [COUNT_WIDTH-1:0]                    drained_count,
  output logic                                      busy
);

  localparam int LAT_W = $clog2(REQ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [SRC_W-1:0]        r_grant;
  logic [SRC_W-1:0]        r_rr_ptr;
  logic [LAT_W-1:0]        r_lat_cnt;
  trace_pkg::trace_output  r_out_trace;
  logic [SRC_W-1:0]        r_out_source;
  logic [COUNT_WIDTH-1:0]  r_count;

  logic [2*NUM_SOURCES-1:0] w_dbl;
  logic [NUM_SOURCES-1:0]   w_rot;
  logic [SRC_W-1:0]         w_off;
  logic [SRC_W:0]           w_sum;
  logic [SRC_W-1:0]         w_pick;
  logic [SRC_W-1:0]         w_next_ptr;
  logic                     w_any;

  // Rotate the present flags so bit 0 is the rr_ptr source; the lowest set bit is the winner.
  assign w_dbl = {src_data_present, src_data_present} >> r_rr_ptr;
  assign w_rot = w_dbl[NUM_SOURCES-1:0];
  assign w_any = |src_data_present;

  always_comb begin
    w_off = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = SRC_W'(i);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (SRC_W+1)'(NUM_SOURCES)) begin
      w_sum = w_sum - (SRC_W+1)'(NUM_SOURCES);
    end
    w_pick = w_sum[SRC_W-1:0];
  end

  assign w_next_ptr = (r_grant == SRC_W'(NUM_SOURCES - 1)) ? '0 : r_grant + SRC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = REQUEST;
      REQUEST: w_next_state = WAIT;
      WAIT:    if (r_lat_cnt == LAT_W'(1)) w_next_state = OUTPUT;
      OUTPUT:  if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The grant is frozen at arbitration; the request goes out even if that source has since emptied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_lat_cnt    <= '0;
      r_out_trace  <= '0;
      r_out_source <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) r_grant <= w_pick;
        end
        REQUEST: begin
          r_lat_cnt <= LAT_W'(REQ_LATENCY);
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          if (r_lat_cnt == LAT_W'(1)) begin
            r_out_trace  <= src_trace_element[r_grant];
            r_out_source <= r_grant;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (r_count != '1) r_count <= r_count + COUNT_WIDTH'(1);
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  assign src_data_request = (r_state == REQUEST) ? (NUM_SOURCES'(1) << r_grant) : '0;
  assign out_valid        = (r_state == OUTPUT);
  assign busy             = (r_state != IDLE);
  assign out_trace        = r_out_trace;
  assign out_source       = r_out_source;
  assign drained_count    = r_count;

endmodule

// File: tb/tb_trace_drain_arbiter.sv
// Bench for trace_drain_arbiter: two instances (latency 1 / 16-bit count, latency 3 / 2-bit count)
// share one stimulus stream and are compared every cycle against a cycle-numbered schedule model.
module tb_trace_drain_arbiter;
  import trace_pkg::*;

  localparam int N     = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] present = '0;
  logic ready = 1'b0;
  trace_output [N-1:0] srcElem = '0;

  logic [N-1:0] reqA, reqB;
  logic validA, validB, busyA, busyB;
  trace_output traceA, traceB;
  logic [1:0] srcA, srcB;
  logic [15:0] cntA;
  logic [1:0] cntB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_drain_arbiter #(.NUM_SOURCES(N), .REQ_LATENCY(LAT_A), .COUNT_WIDTH(16)) dutA (
    .clk(clk), .rst(rst), .src_data_present(present), .src_data_request(reqA),
    .src_trace_element(srcElem), .out_valid(validA), .out_ready(ready), .out_trace(traceA),
    .out_source(srcA), .drained_count(cntA), .busy(busyA)
  );

  trace_drain_arbiter #(.NUM_SOURCES(N), .REQ_LATENCY(LAT_B), .COUNT_WIDTH(2)) dutB (
    .clk(clk), .rst(rst), .src_data_present(present), .src_data_request(reqB),
    .src_trace_element(srcElem), .out_valid(validB), .out_ready(ready), .out_trace(traceB),
    .out_source(srcB), .drained_count(cntB), .busy(busyB)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic randomElems();
    for (int s = 0; s < N; s++) begin
      srcElem[s].core_id            = 4'($urandom);
      srcElem[s].flags              = 4'($urandom);
      srcElem[s].if_data.time_start = $urandom;
      srcElem[s].if_data.time_end   = $urandom;
      srcElem[s].if_data.event_id   = 16'($urandom);
    end
  endtask

  task automatic fixedElems();
    for (int s = 0; s < N; s++) begin
      srcElem[s] = '0;
      srcElem[s].core_id = 4'(s);
      srcElem[s].if_data.time_start = 32'((s + 1) * 100);
    end
  endtask

  // Inputs for the cycle that starts at the next rising edge; outputs of that cycle are settled on return.
  task automatic applyStimulus(input logic r, input logic [N-1:0] p, input logic rd);
    @(posedge clk);
    #1;
    rst     = r;
    present = p;
    ready   = rd;
    randomElems();
  endtask

  // Schedule model: a grant made in idle cycle c requests in c+1, captures in c+1+LAT and
  // offers the record from c+2+LAT until the consumer takes it.
  bit          mLive[2];
  bit          mBusy[2];
  int          mGrant[2];
  int          mReqCyc[2];
  int          mRr[2];
  int          mCount[2];
  int          mCyc[2];
  trace_output mTrace[2];
  int          mSrc[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int lat, cmax;
      logic [N-1:0] expReq, dReq;
      logic expValid, dValid, dBusy;
      trace_output dTrace;
      logic [1:0] dSrc;
      logic [15:0] dCnt;
      string tag;
      lat  = (k == 0) ? LAT_A : LAT_B;
      cmax = (k == 0) ? MAX_A : MAX_B;
      tag  = (k == 0) ? "A" : "B";
      if (k == 0) begin
        dReq = reqA; dValid = validA; dBusy = busyA; dTrace = traceA; dSrc = srcA; dCnt = cntA;
      end else begin
        dReq = reqB; dValid = validB; dBusy = busyB; dTrace = traceB; dSrc = srcB; dCnt = {14'd0, cntB};
      end
      expReq   = (mBusy[k] && mCyc[k] == mReqCyc[k]) ? N'(1 << mGrant[k]) : '0;
      expValid = mBusy[k] && (mCyc[k] >= mReqCyc[k] + lat + 1);
      if (mLive[k]) begin
        checkOutput({tag, ".request"}, 128'(dReq), 128'(expReq));
        checkOutput({tag, ".valid"}, 128'(dValid), 128'(expValid));
        checkOutput({tag, ".busy"}, 128'(dBusy), 128'(mBusy[k]));
        checkOutput({tag, ".count"}, 128'(dCnt), 128'(mCount[k]));
        checkOutput({tag, ".trace"}, 128'(dTrace), 128'(mTrace[k]));
        checkOutput({tag, ".source"}, 128'(dSrc), 128'(mSrc[k]));
      end
      if (rst) begin
        mLive[k] = 1'b1; mBusy[k] = 1'b0; mRr[k] = 0; mCount[k] = 0;
        mTrace[k] = '0; mSrc[k] = 0; mCyc[k] = 0; mReqCyc[k] = 0; mGrant[k] = 0;
      end else begin
        if (!mBusy[k]) begin
          for (int i = N - 1; i >= 0; i--) begin
            if (present[(mRr[k] + i) % N]) mGrant[k] = (mRr[k] + i) % N;
          end
          if (present != '0) begin
            mBusy[k]   = 1'b1;
            mReqCyc[k] = mCyc[k] + 1;
          end
        end else begin
          if (mCyc[k] == mReqCyc[k] + lat) begin
            mTrace[k] = srcElem[mGrant[k]];
            mSrc[k]   = mGrant[k];
          end
          if (expValid && ready) begin
            mCount[k] = (mCount[k] < cmax) ? mCount[k] + 1 : cmax;
            mRr[k]    = (mGrant[k] + 1) % N;
            mBusy[k]  = 1'b0;
          end
        end
        mCyc[k]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nSeen, lastC, n;
    bit found, pend;
    logic [1:0] heldSrc;
    trace_output heldTrace;
    int satExp[5];
    satExp = '{1, 2, 3, 3, 3};

    // Reset held with every source present.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'hF, 1'b0);
      checkOutput("rst.reqA", 128'(reqA), 128'(0));
      checkOutput("rst.reqB", 128'(reqB), 128'(0));
      checkOutput("rst.validA", 128'(validA), 128'(0));
      checkOutput("rst.countA", 128'(cntA), 128'(0));
      checkOutput("rst.busyA", 128'(busyA), 128'(0));
      checkOutput("rst.busyB", 128'(busyB), 128'(0));
      checkOutput("rst.traceA", 128'(traceA), 128'(0));
    end

    // Single source 2, latency 1.
    applyStimulus(1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single.req", 128'(reqA), 128'(4'b0100));
    applyStimulus(1'b0, 4'b0000, 1'b1);
    srcElem[2].if_data.time_start = 32'd300;
    checkOutput("single.reqOff", 128'(reqA), 128'(0));
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single.valid", 128'(validA), 128'(1));
    checkOutput("single.time", 128'(traceA.if_data.time_start), 128'(300));
    checkOutput("single.src", 128'(srcA), 128'(2));
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single.validOff", 128'(validA), 128'(0));
    checkOutput("single.count", 128'(cntA), 128'(1));
    repeat (6) applyStimulus(1'b0, 4'b0000, 1'b1);

    // Rotation with all sources present.
    repeat (2) applyStimulus(1'b1, 4'h0, 1'b1);
    nSeen = 0; lastC = 0;
    for (int c = 0; c < 26; c++) begin
      applyStimulus(1'b0, 4'hF, 1'b1);
      fixedElems();
      if (validA) begin
        if (nSeen < 5) begin
          checkOutput("rot.src", 128'(srcA), 128'(nSeen % 4));
          checkOutput("rot.time", 128'(traceA.if_data.time_start), 128'((nSeen % 4 + 1) * 100));
        end
        if (nSeen > 0) checkOutput("rot.spacing", 128'(c - lastC), 128'(4));
        lastC = c;
        nSeen++;
      end
    end
    checkOutput("rot.records", 128'(nSeen >= 5), 128'(1));

    // Backpressure.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      applyStimulus(1'b0, 4'hF, 1'b0);
      found = validA;
    end
    checkOutput("bp.validRise", 128'(found), 128'(1));
    heldSrc = srcA; heldTrace = traceA;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 4'hF, 1'b0);
      checkOutput("bp.validHeld", 128'(validA), 128'(1));
      checkOutput("bp.srcHeld", 128'(srcA), 128'(heldSrc));
      checkOutput("bp.traceHeld", 128'(traceA), 128'(heldTrace));
      checkOutput("bp.noReq", 128'(reqA), 128'(0));
    end
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("bp.accept", 128'(validA), 128'(1));
    applyStimulus(1'b0, 4'hF, 1'b1);
    checkOutput("bp.dropped", 128'(validA), 128'(0));

    // Reset in the cycle after the request (instance B is mid-wait).
    repeat (2) applyStimulus(1'b1, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("midrst.req", 128'(reqB), 128'(4'b0001));
    applyStimulus(1'b1, 4'h0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 4'h0, 1'b1);
      checkOutput("midrst.noValid", 128'(validB), 128'(0));
      checkOutput("midrst.count", 128'(cntB), 128'(0));
    end
    applyStimulus(1'b0, 4'hF, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("midrst.nextB", 128'(reqB), 128'(4'b0001));
    checkOutput("midrst.nextA", 128'(reqA), 128'(4'b0001));
    repeat (8) applyStimulus(1'b0, 4'h0, 1'b1);

    // Saturation of the 2-bit counter.
    applyStimulus(1'b1, 4'h0, 1'b1);
    n = 0; pend = 1'b0;
    for (int c = 0; c < 100 && (n < 5 || pend); c++) begin
      applyStimulus(1'b0, 4'hF, 1'b1);
      if (pend) begin
        checkOutput("sat.count", 128'(cntB), 128'(satExp[n-1]));
        pend = 1'b0;
      end
      if (validB) begin
        n++;
        pend = 1'b1;
      end
    end
    checkOutput("sat.records", 128'(n), 128'(5));

    // Randomized traffic with occasional resets and backpressure.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(1'($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
